// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory boot loader.
// Stream layout: two length bytes, 4*N instruction bytes, then one XOR checksum byte.
package imem_loader_pkg;

    localparam int BYTE_W         = 8;
    localparam int HDR_LEN        = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = HDR_LEN * BYTE_W;
    localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } ld_state_t;

endpackage

// File: rtl/loader_word_asm.sv
// Little-endian byte-to-word assembler: the first byte lands in [7:0], the fourth in [31:24].
module loader_word_asm
    import imem_loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] in_byte,
    output logic [WORD_W-1:0] word_next,
    output logic              word_last
);

    logic [WORD_W-BYTE_W-1:0] shift_q;
    logic [BCNT_W-1:0]        bcnt_q;

    // word_next is the full word as it stands once the current byte is included
    assign word_next = {in_byte, shift_q};
    assign word_last = byte_en && (bcnt_q == BCNT_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            bcnt_q  <= '0;
        end else if (clear) begin
            shift_q <= '0;
            bcnt_q  <= '0;
        end else if (byte_en) begin
            shift_q <= word_next[WORD_W-1:BYTE_W];
            bcnt_q  <= bcnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte stream into instruction-memory writes,
// verifies an XOR checksum and holds the core in reset until a load completes cleanly.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_error
);

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(IMEM_DEPTH);

    ld_state_t         state;
    logic [LEN_W-1:0]  n_words;
    logic [BYTE_W-1:0] csum;
    logic [ADDR_W-1:0] widx;

    logic              xfer;
    logic              asm_clear;
    logic              byte_en;
    logic              word_last;
    logic              last_word;
    logic [WORD_W-1:0] word_next;
    logic [LEN_W-1:0]  len_full;

    assign xfer      = in_valid & in_ready;
    assign asm_clear = restart && ((state == ST_DONE) || (state == ST_ERROR));
    assign byte_en   = xfer && (state == ST_DATA);
    assign len_full  = {in_data, n_words[BYTE_W-1:0]};
    assign last_word = (LEN_W'(widx) == (n_words - 1'b1));

    loader_word_asm u_word_asm (
        .clock     (clock),
        .reset     (reset),
        .clear     (asm_clear),
        .byte_en   (byte_en),
        .in_byte   (in_data),
        .word_next (word_next),
        .word_last (word_last)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_LEN_LO;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_hold  <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            n_words    <= '0;
            csum       <= '0;
            widx       <= '0;
        end else begin
            imem_we   <= 1'b0;
            load_done <= 1'b0;
            unique case (state)
                ST_LEN_LO: begin
                    // in_ready first rises here after reset release
                    in_ready <= 1'b1;
                    if (xfer) begin
                        n_words[BYTE_W-1:0] <= in_data;
                        csum                <= csum ^ in_data;
                        state               <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (xfer) begin
                        n_words <= len_full;
                        csum    <= csum ^ in_data;
                        if (len_full == '0) begin
                            state <= ST_CSUM;
                        end else if (len_full > DEPTH_L) begin
                            state      <= ST_ERROR;
                            in_ready   <= 1'b0;
                            load_error <= 1'b1;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        csum <= csum ^ in_data;
                        if (word_last) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= widx;
                            imem_wdata <= word_next;
                            widx       <= widx + 1'b1;
                            // in_ready stays high so the write overlaps the checksum cycle
                            if (last_word) begin
                                state <= ST_CSUM;
                            end
                        end
                    end
                end
                ST_CSUM: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        if (in_data == csum) begin
                            state     <= ST_DONE;
                            load_done <= 1'b1;
                            core_hold <= 1'b0;
                        end else begin
                            state      <= ST_ERROR;
                            load_error <= 1'b1;
                        end
                    end
                end
                ST_DONE, ST_ERROR: begin
                    in_ready <= 1'b0;
                    if (restart) begin
                        state      <= ST_LEN_LO;
                        in_ready   <= 1'b1;
                        core_hold  <= 1'b1;
                        load_error <= 1'b0;
                        n_words    <= '0;
                        csum       <= '0;
                        widx       <= '0;
                    end
                end
                default: begin
                    state     <= ST_LEN_LO;
                    in_ready  <= 1'b0;
                    core_hold <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter IMEM_DEPTH, default 256: instruction-memory depth in 32-bit words.
REQ-002 Parameter ADDR_W, default 8: word-index width; SHALL equal clog2(IMEM_DEPTH).
REQ-003 clock  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  8  program byte stream.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  loader accepts a byte this cycle; transfer = in_valid & in_ready.
REQ-008 restart  input  1  one-cycle request to begin a new load; honoured only in DONE or ERROR.
REQ-009 imem_we  output  1  instruction-memory write strobe.
REQ-010 imem_addr  output  ADDR_W  word index written; the core fetches this word at PC>>2.
REQ-011 imem_wdata  output  32  instruction word.
REQ-012 core_hold  output  1  holds the pipeline in reset while high.
REQ-013 load_done  output  1  one-cycle pulse on entry to DONE.
REQ-014 load_error  output  1  level; high while in ERROR.

Function
REQ-015 Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), 4*N instruction bytes, 1 checksum byte.
REQ-016 States: LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR; LEN_LO is the state after reset.
REQ-017 in_ready SHALL be 1 in LEN_LO, LEN_HI, DATA and CSUM, and 0 in DONE and ERROR.
REQ-018 LEN_LO -> LEN_HI on transfer; LEN_HI -> DATA on transfer if 0 < N <= IMEM_DEPTH, -> CSUM if N = 0, -> ERROR if N > IMEM_DEPTH.
REQ-019 In DATA, bytes assemble little-endian: the first byte of a word -> bits [7:0], the fourth -> bits [31:24].
REQ-020 On the transfer of a word's fourth byte, imem_we SHALL be 1 for exactly the next cycle, with imem_wdata equal to the assembled word and imem_addr equal to the word index.
REQ-021 Word index starts at 0 per load and increments after each write; the index never wraps because N <= IMEM_DEPTH is enforced.
REQ-022 DATA -> CSUM after the transfer of the fourth byte of word N-1; in_ready SHALL remain high, so the write cycle overlaps the first CSUM cycle.
REQ-023 The running checksum is the XOR of every accepted byte from LEN_LO through the last data byte.
REQ-024 CSUM transfer: if the byte equals the running checksum -> DONE, else -> ERROR.
REQ-025 core_hold SHALL be 1 in every state except DONE; it SHALL fall in the same cycle load_done pulses.
REQ-026 restart in DONE or ERROR -> LEN_LO next cycle: core_hold = 1, word index and checksum cleared, load_error cleared.
REQ-027 restart in any other state SHALL be ignored.
REQ-028 in_valid while in_ready = 0 SHALL have no effect.
REQ-029 Memory words beyond N-1 SHALL NOT be written; their prior contents are retained.

Reset
REQ-030 Asynchronous assertion SHALL force: state = LEN_LO, in_ready = 0 during reset, imem_we = 0, imem_addr = 0, imem_wdata = 0, core_hold = 1, load_done = 0, load_error = 0, checksum = 0, byte counter = 0.
REQ-031 Reset mid-load SHALL abandon the partial word; no write is issued for it.
REQ-032 in_ready SHALL rise on the first clock edge after reset deasserts.

Structure
REQ-033 Loader state encoding and the stream-format constants (header length 2, bytes per word 4) SHALL reside in a shared package alongside the datapath constants.
REQ-034 One sub-module, loader_word_asm, SHALL implement the byte-to-word shift register and byte counter; the FSM, checksum and core_hold logic reside in the top level.

Verification
REQ-035 Load N=2 with words 0x00500093, 0x00A00113 and a correct checksum -> writes idx0 = 0x00500093 and idx1 = 0x00A00113; load_done pulses; core_hold falls; the pipeline then fetches idx0 at PC = 0.
REQ-036 Same stream with the checksum byte XOR 0x01 -> both writes occur; state ERROR; load_error = 1; core_hold stays 1.
REQ-037 Header N=0x0101 (257 > 256) -> ERROR immediately after LEN_HI; no imem_we.
REQ-038 N=0 followed by checksum 0x00 -> DONE with zero writes.
REQ-039 in_valid toggled randomly (50%) on a 3-word load -> identical writes and addresses as the back-to-back case.
REQ-040 Reset asserted after the 2nd byte of word 1 -> no write to idx1; after release, a full reload succeeds; restart from DONE reasserts core_hold within 1 cycle.
